// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Holds the FSM state encoding, requester count and the rotating-priority pick.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // First set request at or above ptr, wrapping; the downward loop lets the
  // nearest candidate overwrite any farther one.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
    logic [N_REQ-1:0] pick;
    logic [ID_W-1:0]  idx;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot_enc4.sv
// One-hot (or all-zero) 4-bit vector to 2-bit binary index.
// All-zero input yields index 0.
module onehot_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_onehot,
  output logic [ID_W-1:0]  o_id
);

  // With at most one bit set, each index bit is simply an OR of its members.
  assign o_id = {i_onehot[3] | i_onehot[2], i_onehot[3] | i_onehot[1]};

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Every grant ends with one RELEASE cycle, then a fresh IDLE arbitration.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             hold_expired,
  output logic [1:0]       o_dbg_state
);

  // Handshake: req[i] is a level request sampled every rising edge; a grant
  // is owned while gnt[i] is high and ends when req[gnt_id] drops or the
  // hold limit is reached; the grant is visible one cycle after sampling.

  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [N_REQ-1:0] w_winner;
  logic [ID_W-1:0]  w_win_id;
  logic             w_own_req;
  logic             w_hold_done;

  assign w_winner    = rr_pick(req, r_ptr);
  assign w_own_req   = req[gnt_id];
  assign w_hold_done = (r_hold_cnt == LP_HOLD_LAST);
  assign o_dbg_state = r_state;

  onehot_enc4 u_enc (
    .i_onehot (w_winner),
    .o_id     (w_win_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_hold_cnt   <= '0;
      gnt          <= '0;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      hold_expired <= 1'b0;
    end else begin
      hold_expired <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state    <= GRANT;
            gnt        <= w_winner;
            gnt_id     <= w_win_id;
            gnt_valid  <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        GRANT: begin
          // A dropped request wins over the limit, so no timeout pulse then.
          if (!w_own_req || w_hold_done) begin
            r_state      <= RELEASE;
            hold_expired <= w_own_req & w_hold_done;
            r_ptr        <= gnt_id + 2'd1;
            r_hold_cnt   <= '0;
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_valid    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
          gnt        <= '0;
          gnt_id     <= '0;
          gnt_valid  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
          gnt        <= '0;
          gnt_id     <= '0;
          gnt_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum consecutive cycles one grant is held (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, sets the hold-counter width; CNT_W SHALL be able to represent MAX_HOLD-1.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 req  in  4  request vector; bit i high means requester i wants the shared encoder/datapath.
REQ-006 gnt  out  4  one-hot grant vector, registered.
REQ-007 gnt_id  out  2  binary index of the granted requester (bit1 = A1, bit0 = A0 encoding), registered.
REQ-008 gnt_valid  out  1  high exactly when gnt is non-zero.
REQ-009 hold_expired  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-011 In IDLE with req == 0, the FSM SHALL stay in IDLE with all outputs 0.
REQ-012 In IDLE with req != 0, the FSM SHALL select the first set bit searching upward from ptr with wrap (ptr, ptr+1, ... mod 4), enter GRANT, and drive gnt, gnt_id and gnt_valid from the next cycle (latency 1 cycle from sampled req).
REQ-013 In GRANT, gnt, gnt_id and gnt_valid SHALL remain stable and hold_cnt SHALL increment by 1 per cycle, starting at 0 on the first grant cycle.
REQ-014 In GRANT, if the sampled req[gnt_id] is 0, the FSM SHALL enter RELEASE next cycle with hold_expired = 0.
REQ-015 In GRANT, if req[gnt_id] is 1 and hold_cnt == MAX_HOLD-1, the FSM SHALL enter RELEASE with hold_expired = 1 for that one RELEASE cycle.
REQ-016 If the request drop (REQ-014) and the limit (REQ-015) occur in the same cycle, the request drop SHALL take priority and hold_expired SHALL stay 0.
REQ-017 On entering RELEASE, ptr SHALL become (gnt_id+1) mod 4, wrapping 3 -> 0.
REQ-018 In RELEASE, gnt, gnt_id and gnt_valid SHALL be 0; hold_cnt SHALL clear; the next state SHALL be IDLE unconditionally.
REQ-019 The minimum gap between two grants SHALL be 2 cycles (RELEASE, then IDLE arbitration).
REQ-020 A requester still asserting after a timeout SHALL only be re-granted after every other active requester has been served once.
REQ-021 A request withdrawn in the same cycle its grant appears SHALL still receive exactly one grant cycle.
REQ-022 gnt SHALL never have more than one bit set, and gnt_id SHALL always equal the encoding of gnt (0 when gnt == 0).
REQ-023 Changes to req bits other than req[gnt_id] during GRANT SHALL have no effect until the next IDLE.

Reset
REQ-024 While rst_n == 0 at a clock edge, the block SHALL set state = IDLE, ptr = 0, hold_cnt = 0, gnt = 0, gnt_id = 0, gnt_valid = 0 and hold_expired = 0, regardless of req.
REQ-025 A reset asserted during GRANT SHALL drop the grant on the following edge; no RELEASE cycle and no hold_expired pulse SHALL occur.
REQ-026 Arbitration SHALL resume on the first edge with rst_n == 1, starting from ptr = 0.

Structure
REQ-027 Package arb_pkg SHALL hold the state enum (IDLE, GRANT, RELEASE) and the constants N_REQ = 4 and ID_W = 2.
REQ-028 One sub-module, onehot_enc4, SHALL convert the one-hot winner to the 2-bit index; it is combinational and its input is guaranteed one-hot or zero.

Verification
REQ-029 Reset priority: rst_n = 0 for 3 cycles with req = 1111 -> gnt = 0000, gnt_id = 00, gnt_valid = 0 throughout.
REQ-030 Single requester: req = 0001 for 4 cycles, then 0000 -> gnt = 0001 and gnt_id = 00 from cycle 1 through 4, RELEASE at cycle 5, hold_expired = 0.
REQ-031 Round-robin timeout: req = 1111 held, MAX_HOLD = 8 -> grants in order id 0, 1, 2, 3, 0, each 8 cycles, a hold_expired pulse after each, and a 2-cycle gap between grants.
REQ-032 Sparse requests: req = 1010 held -> grant order id 1, 3, 1, with gnt always one-hot and gnt_id consistent with it.
REQ-033 Reset mid-grant: rst_n pulsed low for 1 cycle during the grant to id 2 -> gnt = 0000 on the next edge; then req = 0101 -> grant id 0 first.
REQ-034 Simultaneous drop and limit: req[gnt_id] falls on the cycle where hold_cnt == 7 -> RELEASE with hold_expired = 0.
